// File: rtl/uart_axil_console_master_if.sv
// AXI4-Lite bus between the console master and the UART-Lite slave.
interface uart_axil_console_master_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/uart_axil_console_master.sv
// Console byte-stream to AXI UART-Lite bridge: buffers TX bytes, polls STAT,
// drains the UART RX FIFO into a valid/ready stream. One AXI transaction at a time.
module uart_axil_console_master #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                TXQ_DEPTH = 16,
    parameter int                POLL_GAP  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_byte,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       err,
    uart_axil_console_master_if.master m
);
    localparam logic [ADDR_W-1:0] RX_ADDR   = BASE_ADDR;
    localparam logic [ADDR_W-1:0] TX_ADDR   = BASE_ADDR + ADDR_W'(4);
    localparam logic [ADDR_W-1:0] STAT_ADDR = BASE_ADDR + ADDR_W'(8);
    localparam int PW = $clog2(TXQ_DEPTH);
    localparam int GW = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;

    typedef enum logic [2:0] {IDLE, STAT_AR, STAT_R, RX_AR, RX_R, WR, WR_B} state_t;
    state_t state;

    // ---------------- TX byte FIFO ----------------
    logic [7:0]    mem [TXQ_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          push, pop, empty;

    assign tx_ready = (count != (PW+1)'(TXQ_DEPTH));
    assign empty    = (count == '0);
    assign push     = tx_valid && tx_ready;
    // A byte leaves the queue only once its write response is back (OKAY or not).
    assign pop      = (state == WR_B) && m.bvalid && m.bready;

    // FIFO storage; contents need no reset, the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx_byte;
    end

    // FIFO pointers and occupancy; simultaneous push/pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // ---------------- poll / transfer FSM ----------------
    logic [GW-1:0] gap;
    logic          gap_done;
    assign gap_done = (gap >= GW'(POLL_GAP));

    // Only the low byte of RX data and a few STAT bits carry meaning.
    logic unused_rdata;
    assign unused_rdata = ^m.rdata[31:8];

    // Main sequencer: all bus outputs, rx stream and err are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gap       <= '0;
            m.awaddr  <= '0;
            m.awvalid <= 1'b0;
            m.wdata   <= '0;
            m.wstrb   <= '0;
            m.wvalid  <= 1'b0;
            m.bready  <= 1'b0;
            m.araddr  <= '0;
            m.arvalid <= 1'b0;
            m.rready  <= 1'b0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // Poll only if there is work: bytes to send or room for an RX byte.
                    if (gap_done && (!empty || !rx_valid)) begin
                        m.araddr  <= STAT_ADDR;
                        m.arvalid <= 1'b1;
                        state     <= STAT_AR;
                    end else if (!gap_done) begin
                        gap <= gap + GW'(1);
                    end
                end
                STAT_AR: if (m.arready) begin
                    m.arvalid <= 1'b0;
                    m.rready  <= 1'b1;
                    state     <= STAT_R;
                end
                STAT_R: if (m.rvalid) begin
                    m.rready <= 1'b0;
                    if (m.rresp != 2'b00) err <= 1'b1;
                    // RX drain wins over TX so the UART RX FIFO does not overflow.
                    if (m.rdata[0] && !rx_valid) begin
                        m.araddr  <= RX_ADDR;
                        m.arvalid <= 1'b1;
                        state     <= RX_AR;
                    end else if (!m.rdata[3] && !empty) begin
                        m.awaddr  <= TX_ADDR;
                        m.awvalid <= 1'b1;
                        m.wdata   <= {24'h0, mem[rd_ptr]};
                        m.wstrb   <= 4'h1;
                        m.wvalid  <= 1'b1;
                        state     <= WR;
                    end else begin
                        gap   <= '0;
                        state <= IDLE;
                    end
                end
                RX_AR: if (m.arready) begin
                    m.arvalid <= 1'b0;
                    m.rready  <= 1'b1;
                    state     <= RX_R;
                end
                RX_R: if (m.rvalid) begin
                    m.rready <= 1'b0;
                    if (m.rresp == 2'b00) begin
                        rx_byte  <= m.rdata[7:0];
                        rx_valid <= 1'b1;
                    end else begin
                        err <= 1'b1;
                    end
                    gap   <= '0;
                    state <= IDLE;
                end
                WR: begin
                    // AW and W complete independently; move on once both are accepted.
                    if (m.awready) m.awvalid <= 1'b0;
                    if (m.wready)  m.wvalid  <= 1'b0;
                    if ((!m.awvalid || m.awready) && (!m.wvalid || m.wready)) begin
                        m.bready <= 1'b1;
                        state    <= WR_B;
                    end
                end
                WR_B: if (m.bvalid) begin
                    m.bready <= 1'b0;
                    if (m.bresp != 2'b00) err <= 1'b1;
                    gap   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_axil_console_master.sv
// Directed bench with a reactive UART-Lite slave model and write/RX scoreboards.
module tb_uart_axil_console_master;
    localparam int          ADDR_W    = 32;
    localparam logic [31:0] BASE      = 32'h4060_0000;
    localparam int          TXQ_DEPTH = 16;
    localparam int          POLL_GAP  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_byte = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       err;

    uart_axil_console_master_if #(.ADDR_W(ADDR_W)) m_if ();

    uart_axil_console_master #(
        .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .TXQ_DEPTH(TXQ_DEPTH), .POLL_GAP(POLL_GAP)
    ) dut (
        .clk(clk), .rst(rst),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .err(err), .m(m_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // slave model knobs and statistics
    logic [31:0] stat_val = '0;
    logic [7:0]  rx_data = '0;
    logic [1:0]  bresp_q[$];
    logic [7:0]  exp_wr_q[$];
    logic [7:0]  exp_rx_q[$];
    int          order_q[$];
    int aw_delay = 0, w_delay = 0;
    bit stall = 0, saw_w_alone = 0;
    int n_aw = 0, n_b = 0, n_stat = 0, n_rxrd = 0, last_end = -1000;

    int aw_cnt = 0, w_cnt = 0;
    bit got_aw = 0, got_w = 0, rd_stat = 0;
    logic p_arv = 0, p_arr = 0, p_rv = 0, p_rr = 0, p_awv = 0, p_awr = 0;
    logic p_wv = 0, p_wr = 0, p_bv = 0, p_br = 0;
    logic [31:0] p_araddr = '0, p_awaddr = '0, p_wdata = '0;
    logic [3:0]  p_wstrb = '0;

    // Slave: acts at negedge; a handshake happened at the previous posedge iff
    // valid&ready were both high as left by the previous negedge.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst) begin
            m_if.arready = 0; m_if.rvalid = 0; m_if.rdata = 0; m_if.rresp = 0;
            m_if.awready = 0; m_if.wready = 0; m_if.bvalid = 0; m_if.bresp = 0;
            aw_cnt = 0; w_cnt = 0; got_aw = 0; got_w = 0;
        end else begin
            if (p_arv && !p_arr) begin
                chk("ar_hold", m_if.arvalid, 1);
                chk("araddr_stable", m_if.araddr, p_araddr);
            end
            if (p_awv && !p_awr) begin
                chk("aw_hold", m_if.awvalid, 1);
                chk("awaddr_stable", m_if.awaddr, p_awaddr);
            end
            if (p_wv && !p_wr) begin
                chk("w_hold", m_if.wvalid, 1);
                chk("wdata_stable", m_if.wdata, p_wdata);
            end
            // AR / R
            if (p_arv && p_arr) begin
                m_if.arready = 0;
                rd_stat = (p_araddr == BASE + 32'h8);
                chk("araddr_legal", (p_araddr == BASE + 32'h8) || (p_araddr == BASE), 1);
                if (rd_stat) begin
                    chk("poll_gap", (cyc - last_end) >= POLL_GAP + 1, 1);
                    m_if.rdata = stat_val;
                end else begin
                    n_rxrd++;
                    order_q.push_back(1);
                    m_if.rdata = {24'h0, rx_data};
                end
                m_if.rresp = 2'b00;
                m_if.rvalid = 1;
            end else if (!stall && m_if.arvalid && !m_if.arready && !m_if.rvalid) begin
                m_if.arready = 1;
            end
            if (p_rv && p_rr) begin
                m_if.rvalid = 0;
                if (rd_stat) n_stat++;
                last_end = cyc;
            end
            // AW
            if (p_awv && p_awr) begin
                m_if.awready = 0; got_aw = 1; aw_cnt = 0; n_aw++;
                order_q.push_back(2);
                chk("awaddr", p_awaddr, BASE + 32'h4);
            end else if (m_if.awvalid && !m_if.awready) begin
                if (aw_cnt >= aw_delay) m_if.awready = 1; else aw_cnt++;
            end
            // W with scoreboard
            if (p_wv && p_wr) begin
                m_if.wready = 0; got_w = 1; w_cnt = 0;
                chk("wstrb", p_wstrb, 4'h1);
                if (exp_wr_q.size() == 0) chk("wr_unexpected", exp_wr_q.size(), 1);
                else begin
                    e = exp_wr_q.pop_front();
                    chk("wdata", p_wdata, {24'h0, e});
                end
            end else if (m_if.wvalid && !m_if.wready) begin
                if (w_cnt >= w_delay) m_if.wready = 1; else w_cnt++;
            end
            if (m_if.awvalid && !m_if.wvalid) saw_w_alone = 1;
            // B
            if (p_bv && p_br) begin
                m_if.bvalid = 0; n_b++; last_end = cyc;
            end else if (got_aw && got_w && !m_if.bvalid) begin
                m_if.bresp = 2'b00;
                if (bresp_q.size() != 0) m_if.bresp = bresp_q.pop_front();
                m_if.bvalid = 1; got_aw = 0; got_w = 0;
            end
        end
        p_arv = m_if.arvalid; p_arr = m_if.arready; p_araddr = m_if.araddr;
        p_rv = m_if.rvalid;   p_rr = m_if.rready;
        p_awv = m_if.awvalid; p_awr = m_if.awready; p_awaddr = m_if.awaddr;
        p_wv = m_if.wvalid;   p_wr = m_if.wready;   p_wdata = m_if.wdata; p_wstrb = m_if.wstrb;
        p_bv = m_if.bvalid;   p_br = m_if.bready;
    end

    // RX stream scoreboard: compare on each consumer handshake.
    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst && rx_valid && rx_ready) begin
            if (exp_rx_q.size() == 0) chk("rx_unexpected", exp_rx_q.size(), 1);
            else begin
                e = exp_rx_q.pop_front();
                chk("rx_byte", rx_byte, e);
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        tx_byte = b; tx_valid = 1;
        @(negedge clk);
        chk("push_ready", tx_ready, 1);
        exp_wr_q.push_back(b);
        step();
        tx_valid = 0;
    endtask

    task automatic wait_b(input int target, input string tag);
        for (int i = 0; i < 3000 && n_b < target; i++) @(negedge clk);
        chk(tag, n_b >= target, 1);
    endtask

    initial begin
        int b0, s0, a0, r0, acc;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctl", {m_if.arvalid, m_if.awvalid, m_if.wvalid, m_if.bready, m_if.rready, rx_valid, err}, 0);
        chk("rst_addr", m_if.araddr | m_if.awaddr, 0);
        chk("rst_data", {m_if.wdata[23:0], m_if.wstrb, rx_byte}, 0);
        chk("rst_tx_ready", tx_ready, 1);
        step();
        rst = 0;

        // 1: single byte, TX FIFO has room
        repeat (20) step();
        stat_val = 32'h4; b0 = n_b; s0 = n_stat;
        push_byte(8'h41);
        wait_b(b0 + 1, "t1_b_done");
        chk("t1_stat_polled", n_stat > s0, 1);
        chk("t1_tx_ready", tx_ready, 1);
        chk("t1_wrq_empty", exp_wr_q.size(), 0);

        // 2: UART TX full for several polls
        step();
        stat_val = 32'h8; a0 = n_aw; b0 = n_b;
        push_byte(8'h42);
        s0 = n_stat;
        for (int i = 0; i < 1000 && n_stat < s0 + 3; i++) @(negedge clk);
        chk("t2_polls", n_stat >= s0 + 3, 1);
        chk("t2_no_aw_full", n_aw, a0);
        step();
        stat_val = 32'h4;
        wait_b(b0 + 1, "t2_b_done");
        chk("t2_aw_once", n_aw, a0 + 1);

        // 3: RX byte held until consumer accepts
        step();
        stat_val = 32'h1; rx_data = 8'h5A; exp_rx_q.push_back(8'h5A); r0 = n_rxrd;
        for (int i = 0; i < 1000 && !rx_valid; i++) @(negedge clk);
        chk("t3_rx_valid", rx_valid, 1);
        chk("t3_rx_byte", rx_byte, 8'h5A);
        repeat (40) @(negedge clk);
        chk("t3_single_rd", n_rxrd, r0 + 1);
        chk("t3_held", {rx_valid, rx_byte}, {1'b1, 8'h5A});
        step();
        stat_val = 32'h0; rx_ready = 1;
        step();
        rx_ready = 0;
        @(negedge clk);
        chk("t3_rx_cleared", rx_valid, 0);
        chk("t3_rxq_empty", exp_rx_q.size(), 0);

        // 4: RX and TX both pending -> RX first
        step();
        push_byte(8'h43);
        rx_data = 8'h33; exp_rx_q.push_back(8'h33); order_q.delete(); b0 = n_b;
        stat_val = 32'h5;
        wait_b(b0 + 1, "t4_b_done");
        chk("t4_rx_first", order_q[0], 1);
        chk("t4_tx_second", order_q[1], 2);
        step();
        stat_val = 32'h0; rx_ready = 1;
        step();
        rx_ready = 0;
        @(negedge clk);
        chk("t4_rxq_empty", exp_rx_q.size(), 0);

        // 5: wready ahead of awready
        step();
        stat_val = 32'h4; aw_delay = 2; w_delay = 0; saw_w_alone = 0; b0 = n_b;
        push_byte(8'h44);
        wait_b(b0 + 1, "t5_b_done");
        repeat (30) @(negedge clk);
        chk("t5_one_b", n_b, b0 + 1);
        chk("t5_w_alone", saw_w_alone, 1);
        step();
        aw_delay = 0;

        // 6: fill FIFO with bus stalled, error response, reset mid-write
        stat_val = 32'h0; stall = 1;
        repeat (30) step();
        acc = 0;
        for (int i = 0; i < TXQ_DEPTH + 1; i++) begin
            tx_byte = 8'h60 + 8'(i); tx_valid = 1;
            @(negedge clk);
            if (tx_ready) begin acc++; exp_wr_q.push_back(tx_byte); end
            step();
        end
        tx_valid = 0;
        @(negedge clk);
        chk("t6_accepted", acc, TXQ_DEPTH);
        chk("t6_full", tx_ready, 0);
        step();
        bresp_q.push_back(2'b10); stall = 0; stat_val = 32'h4; b0 = n_b;
        wait_b(b0 + 1, "t6_b_err");
        chk("t6_err_set", err, 1);
        wait_b(b0 + 2, "t6_b_next");
        chk("t6_err_sticky", err, 1);
        chk("t6_tx_ready_back", tx_ready, 1);
        step();
        aw_delay = 30; w_delay = 30;
        for (int i = 0; i < 1000 && !m_if.awvalid; i++) @(negedge clk);
        chk("t6_in_wr", m_if.awvalid, 1);
        step();
        rst = 1;
        repeat (2) @(negedge clk);
        chk("t6_rst_valids", {m_if.arvalid, m_if.awvalid, m_if.wvalid, m_if.bready, m_if.rready}, 0);
        chk("t6_rst_flags", {tx_ready, err, rx_valid}, 3'b100);
        exp_wr_q.delete();
        step();
        rst = 0; aw_delay = 0; w_delay = 0;

        // 7: clean operation after reset, FIFO really flushed
        repeat (5) step();
        b0 = n_b;
        push_byte(8'h7E);
        wait_b(b0 + 1, "t7_b_done");
        repeat (40) @(negedge clk);
        chk("t7_one_b", n_b, b0 + 1);
        chk("t7_wrq_empty", exp_wr_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
